// File: rtl/pp_drive_gen.sv
// Complementary push-pull drive pair with dead-time, and a button-adjustable half-period.
// A new half-period is applied only at a period boundary, or at once while the drive is disabled.
module pp_drive_gen #(
  parameter int CNT_W    = 24,
  parameter int HALF_DEF = 15110,
  parameter int HALF_MIN = 1000,
  parameter int HALF_MAX = 32767,
  parameter int STEP     = 511,
  parameter int DEAD     = 8,
  parameter int DEB_CYC  = 500000,
  parameter int RPT_CYC  = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             btn_down_n,
  input  logic             btn_up_n,
  output logic             pp1,
  output logic             pp2,
  output logic             led_adj,
  output logic [CNT_W-1:0] half_period,
  output logic [CNT_W-1:0] half_pending,
  output logic             busy
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int RPT_W = $clog2(RPT_CYC + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_CYC - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEAD_C    = CNT_W'(DEAD);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0] HALF_RST  = CNT_W'(HALF_DEF);

  localparam logic [CNT_W:0] STEP_X = (CNT_W + 1)'(STEP);
  localparam logic [CNT_W:0] MIN_X  = (CNT_W + 1)'(HALF_MIN);
  localparam logic [CNT_W:0] MAX_X  = (CNT_W + 1)'(HALF_MAX);

  typedef enum logic [1:0] {ST_DA, ST_A, ST_DB, ST_B} state_e;

  // Button index 0 is "up", index 1 is "down"; all button state is active-high "pressed".
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];
  logic [RPT_W-1:0] rpt_cnt_q [2];
  logic [RPT_W-1:0] rpt_cnt_d [2];
  logic [1:0]       press_s, rpt_ev_s, ev_s;
  logic             both_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic [CNT_W-1:0] half_pending_q, half_pending_d;
  logic [CNT_W-1:0] act_last_s;
  logic [CNT_W:0]   pend_x_s, sum_x_s, cand_x_s;
  logic             pp1_q, pp1_d, pp2_q, pp2_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;

  // Synchroniser, debounce and auto-repeat for both buttons.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      press_s[i]   = 1'b0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i]   = sync2_q[i];
          press_s[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end

    both_s = deb_d[0] & deb_d[1];

    // The repeat timer restarts on every event, and idles at zero when released or both held.
    for (int i = 0; i < 2; i++) begin
      rpt_ev_s[i]  = 1'b0;
      rpt_cnt_d[i] = '0;
      if (!deb_d[i] || both_s || press_s[i]) begin
        rpt_cnt_d[i] = '0;
      end else if (rpt_cnt_q[i] == RPT_LAST) begin
        rpt_ev_s[i]  = 1'b1;
        rpt_cnt_d[i] = '0;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_ONE;
      end
    end

    ev_s = (press_s | rpt_ev_s) & {2{~both_s}};
  end

  // Saturating half-period request; one bit of headroom keeps the sum from wrapping.
  always_comb begin
    pend_x_s = {1'b0, half_pending_q};
    sum_x_s  = pend_x_s + STEP_X;
    cand_x_s = pend_x_s;
    if (ev_s[0]) begin
      if (sum_x_s > MAX_X) begin
        cand_x_s = MAX_X;
      end else begin
        cand_x_s = sum_x_s;
      end
    end else if (ev_s[1]) begin
      if (pend_x_s < (MIN_X + STEP_X)) begin
        cand_x_s = MIN_X;
      end else begin
        cand_x_s = pend_x_s - STEP_X;
      end
    end else begin
      cand_x_s = pend_x_s;
    end
    half_pending_d = cand_x_s[CNT_W-1:0];
    led_d          = led_q ^ (half_pending_d != half_pending_q);
  end

  // Drive sequencer: DA -> A -> DB -> B, each phase timed by ph_q.
  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q + CNT_ONE;
    half_period_d = half_period_q;
    act_last_s    = half_period_q - DEAD_C - CNT_ONE;
    if (!en) begin
      state_d       = ST_DA;
      ph_d          = '0;
      half_period_d = half_pending_q;
    end else begin
      case (state_q)
        ST_DA: begin
          if (ph_q == DEAD_LAST) begin
            state_d = ST_A;
            ph_d    = '0;
          end else begin
            state_d = ST_DA;
          end
        end
        ST_A: begin
          if (ph_q == act_last_s) begin
            state_d = ST_DB;
            ph_d    = '0;
          end else begin
            state_d = ST_A;
          end
        end
        ST_DB: begin
          if (ph_q == DEAD_LAST) begin
            state_d = ST_B;
            ph_d    = '0;
          end else begin
            state_d = ST_DB;
          end
        end
        ST_B: begin
          if (ph_q == act_last_s) begin
            state_d       = ST_DA;
            ph_d          = '0;
            half_period_d = half_pending_q;
          end else begin
            state_d = ST_B;
          end
        end
        default: begin
          state_d = ST_DA;
          ph_d    = '0;
        end
      endcase
    end
    pp1_d  = en & (state_d == ST_A);
    pp2_d  = en & (state_d == ST_B);
    busy_d = (half_pending_d != half_period_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= 2'b00;
      sync2_q        <= 2'b00;
      deb_q          <= 2'b00;
      deb_cnt_q      <= '{default: '0};
      rpt_cnt_q      <= '{default: '0};
      state_q        <= ST_DA;
      ph_q           <= '0;
      half_period_q  <= HALF_RST;
      half_pending_q <= HALF_RST;
      pp1_q          <= 1'b0;
      pp2_q          <= 1'b0;
      led_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sync1_q        <= ~{btn_down_n, btn_up_n};
      sync2_q        <= sync1_q;
      deb_q          <= deb_d;
      deb_cnt_q      <= deb_cnt_d;
      rpt_cnt_q      <= rpt_cnt_d;
      state_q        <= state_d;
      ph_q           <= ph_d;
      half_period_q  <= half_period_d;
      half_pending_q <= half_pending_d;
      pp1_q          <= pp1_d;
      pp2_q          <= pp2_d;
      led_q          <= led_d;
      busy_q         <= busy_d;
    end
  end

  assign pp1          = pp1_q;
  assign pp2          = pp2_q;
  assign led_adj      = led_q;
  assign half_period  = half_period_q;
  assign half_pending = half_pending_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pp_drive_gen.sv
// Self-checking bench for pp_drive_gen: a period-position model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pp_drive_gen;

  localparam int CNT_W = 24, HALF_DEF = 10, HALF_MIN = 6, HALF_MAX = 16, STEP = 3;
  localparam int DEAD = 2, DEB = 4, RPT = 20;

  logic clk, rst, en, btn_down_n, btn_up_n;
  logic pp1, pp2, led_adj, busy;
  logic [CNT_W-1:0] half_period, half_pending;

  int n_chk = 0;
  int n_fail = 0;

  pp_drive_gen #(
    .CNT_W(CNT_W), .HALF_DEF(HALF_DEF), .HALF_MIN(HALF_MIN), .HALF_MAX(HALF_MAX),
    .STEP(STEP), .DEAD(DEAD), .DEB_CYC(DEB), .RPT_CYC(RPT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .btn_down_n(btn_down_n), .btn_up_n(btn_up_n),
    .pp1(pp1), .pp2(pp2), .led_adj(led_adj), .half_period(half_period),
    .half_pending(half_pending), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: position t inside the current period of length 2*m_h, plus button behaviour.
  int m_t, m_h, m_pend;
  bit m_led, m_valid;
  bit m_s1[2], m_s2[2], m_prev[2], m_deb[2];
  int m_run[2], m_since[2];

  task automatic model_step();
    bit raw[2];
    bit press[2];
    bit ev[2];
    bit both, s;
    int np, old_pend;
    raw[0] = !btn_up_n;
    raw[1] = !btn_down_n;
    if (rst) begin
      m_t = 0; m_h = HALF_DEF; m_pend = HALF_DEF; m_led = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_prev[b] = 0; m_deb[b] = 0; m_run[b] = 0; m_since[b] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        s = m_s2[b]; m_s2[b] = m_s1[b]; m_s1[b] = raw[b];
        m_run[b] = (s == m_prev[b]) ? m_run[b] + 1 : 1;
        m_prev[b] = s;
        press[b] = 0;
        if (s != m_deb[b] && m_run[b] >= DEB) begin
          m_deb[b] = s;
          press[b] = s;
        end
      end
      both = m_deb[0] && m_deb[1];
      for (int b = 0; b < 2; b++) begin
        ev[b] = press[b];
        if (!m_deb[b] || both || press[b]) m_since[b] = 0;
        else begin
          m_since[b]++;
          if (m_since[b] == RPT) begin ev[b] = 1; m_since[b] = 0; end
        end
        if (both) ev[b] = 0;
      end
      old_pend = m_pend;
      np = m_pend;
      if (ev[0]) np = (m_pend + STEP > HALF_MAX) ? HALF_MAX : m_pend + STEP;
      else if (ev[1]) np = (m_pend - STEP < HALF_MIN) ? HALF_MIN : m_pend - STEP;
      if (np != m_pend) m_led = !m_led;
      m_pend = np;
      if (!en) begin m_t = 0; m_h = old_pend; end
      else if (m_t == 2 * m_h - 1) begin m_t = 0; m_h = old_pend; end
      else m_t++;
    end
  endtask

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
      m_valid = 1'b1;
    end
  end

  // Per-cycle comparison and pulse-width / period measurement.
  int run1 = 0, run2 = 0, w1 = 0, w2 = 0, cyc = 0, last_rise = 0, per1 = 0;
  bit pp1_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        chk("pp1", int'(pp1), int'(m_t >= DEAD && m_t < m_h));
        chk("pp2", int'(pp2), int'(m_t >= m_h + DEAD && m_t < 2 * m_h));
        chk("no_overlap", int'(pp1 & pp2), 0);
        chk("led_adj", int'(led_adj), int'(m_led));
        chk("half_period", int'(half_period), m_h);
        chk("half_pending", int'(half_pending), m_pend);
        chk("busy", int'(busy), int'(m_pend != m_h));
        if (pp1 === 1'b1) run1++; else if (run1 != 0) begin w1 = run1; run1 = 0; end
        if (pp2 === 1'b1) run2++; else if (run2 != 0) begin w2 = run2; run2 = 0; end
        if (pp1 === 1'b1 && !pp1_prev) begin per1 = cyc - last_rise; last_rise = cyc; end
        pp1_prev = (pp1 === 1'b1);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_btn(input bit up, input bit dn, input int hold, input int rel);
    btn_up_n = !up;
    btn_down_n = !dn;
    cycles(hold);
    btn_up_n = 1'b1;
    btn_down_n = 1'b1;
    cycles(rel);
  endtask

  function automatic int cur(input int sel);
    case (sel)
      0: return int'(pp1);
      1: return int'(pp2);
      default: return int'(half_period);
    endcase
  endfunction

  task automatic wait_for(input int sel, input int val, input string nm);
    int i;
    i = 0;
    while (cur(sel) != val && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk(nm, cur(sel), val);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  int toggles;
  bit led_last;

  initial begin
    rst = 1'b1; en = 1'b1; btn_up_n = 1'b1; btn_down_n = 1'b1;
    cycles(1);
    chk("rst_half_period", int'(half_period), 10);
    chk("rst_half_pending", int'(half_pending), 10);
    chk("rst_pp1", int'(pp1), 0);
    chk("rst_led", int'(led_adj), 0);
    chk("rst_busy", int'(busy), 0);
    cycles(1);
    rst = 1'b0;
    cycles(45);
    chk("pp1_width_10", w1, 8);
    chk("pp2_width_10", w2, 8);
    chk("period_10", per1, 20);

    // Too-short press is filtered out.
    hold_btn(1, 0, 3, 12);
    chk("short_press_pending", int'(half_pending), 10);
    chk("short_press_led", int'(led_adj), 0);

    // Accepted press: request changes now, applied at the next period boundary.
    hold_btn(1, 0, 6, 0);
    chk("press_pending", int'(half_pending), 13);
    chk("press_led", int'(led_adj), 1);
    chk("press_busy", int'(busy), 1);
    cycles(12);
    wait_for(2, 13, "applied_13");
    cycles(60);
    chk("pp1_width_13", w1, 11);
    chk("period_13", per1, 26);

    // Long hold: auto-repeat up to the clamp, LED toggles exactly twice.
    do_reset();
    toggles = 0;
    led_last = led_adj;
    btn_up_n = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 60) btn_up_n = 1'b1;
      @(negedge clk);
      if (led_adj != led_last) toggles++;
      led_last = led_adj;
    end
    chk("repeat_pending", int'(half_pending), 16);
    chk("repeat_toggles", toggles, 2);

    // Both buttons together are ignored.
    hold_btn(1, 1, 50, 20);
    chk("both_pending", int'(half_pending), 16);
    chk("both_led", int'(led_adj), 0);

    // Down presses to the lower clamp.
    do_reset();
    hold_btn(0, 1, 6, 12);
    chk("down1_pending", int'(half_pending), 7);
    chk("down1_led", int'(led_adj), 1);
    hold_btn(0, 1, 6, 12);
    chk("down2_pending", int'(half_pending), 6);
    chk("down2_led", int'(led_adj), 0);
    hold_btn(0, 1, 6, 12);
    chk("down3_pending", int'(half_pending), 6);
    chk("down3_led", int'(led_adj), 0);

    // Enable drop during A applies the request at once; re-enable starts with dead-time.
    wait_for(2, 6, "applied_6");
    hold_btn(1, 0, 6, 12);
    chk("up_to_9", int'(half_pending), 9);
    wait_for(0, 1, "reach_A");
    en = 1'b0;
    cycles(1);
    chk("en_off_pp1", int'(pp1), 0);
    chk("en_off_half_period", int'(half_period), 9);
    chk("en_off_busy", int'(busy), 0);
    cycles(3);
    en = 1'b1;
    cycles(1);
    chk("reen_dead1", int'(pp1), 0);
    cycles(1);
    chk("reen_pp1_on", int'(pp1), 1);

    // Reset during B drops the output and discards the request.
    hold_btn(1, 0, 6, 12);
    chk("up_to_12", int'(half_pending), 12);
    wait_for(1, 1, "reach_B");
    rst = 1'b1;
    cycles(1);
    chk("rstB_pp2", int'(pp2), 0);
    chk("rstB_half_period", int'(half_period), 10);
    chk("rstB_half_pending", int'(half_pending), 10);
    rst = 1'b0;
    cycles(45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
